// File: rtl/spi_master_if.sv
// Host request/response and SPI pin bundle for spi_master.
// The master modport is the DUT view; the slave modport is the host plus SPI responder side.
interface spi_master_if;
   logic       start;
   logic       rw;
   logic [6:0] addr;
   logic [7:0] wdata;
   logic       busy;
   logic       done;
   logic [7:0] rdata;
   logic       sck;
   logic       nss;
   logic       mosi;
   logic       miso;

   modport master (
      input  start, rw, addr, wdata, miso,
      output busy, done, rdata, sck, nss, mosi
   );

   modport slave (
      output start, rw, addr, wdata, miso,
      input  busy, done, rdata, sck, nss, mosi
   );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 initiator issuing one 16-bit {rw, addr, data} frame per host request.
// Define SPI_MISO_SYNC_EN to pass miso through a 2-flop synchronizer (needs CLK_DIV >= 3).
module spi_master #(
   parameter int unsigned CLK_DIV = 4
) (
   input logic          clk,
   input logic          reset_n,
   spi_master_if.master bus
);

   typedef enum logic [2:0] {StIdle, StSetup, StXfer, StHold, StGap} state_e;

   localparam logic [7:0] Reload = 8'(CLK_DIV - 1);

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [4:0]  hp_q, hp_d;
   logic [15:0] sreg_q, sreg_d;
   logic [7:0]  rshift_q, rshift_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        is_read_q, is_read_d;
   logic        sck_q, sck_d;
   logic        nss_q, nss_d;
   logic        mosi_q, mosi_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic rise;
   logic smp_en;
   logic miso_smp;

   // hp_q counts completed half-periods; rising edge n happens at hp_q == 2(n-1)
   assign rise = (state_q == StXfer) && (cnt_q == '0) && !sck_q;

`ifdef SPI_MISO_SYNC_EN
   logic [1:0] sync_q;
   logic [1:0] smp_q, smp_d;

   // Data-byte samples are delayed two cycles to line up with the synchronizer output
   assign smp_d    = {smp_q[0], rise & is_read_q & hp_q[4]};
   assign smp_en   = smp_q[1];
   assign miso_smp = sync_q[1];
`else
   assign smp_en   = rise & is_read_q & hp_q[4];
   assign miso_smp = bus.miso;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hp_d      = hp_q;
      sreg_d    = sreg_q;
      rshift_d  = rshift_q;
      rdata_d   = rdata_q;
      is_read_d = is_read_q;
      sck_d     = sck_q;
      nss_d     = nss_q;
      mosi_d    = mosi_q;
      busy_d    = busy_q;
      done_d    = 1'b0;

      if (smp_en) begin
         rshift_d = {rshift_q[6:0], miso_smp};
      end
      if (cnt_q != '0) begin
         cnt_d = cnt_q - 8'd1;
      end

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d   = StSetup;
               cnt_d     = Reload;
               sreg_d    = {bus.rw, bus.addr, bus.rw ? 8'h00 : bus.wdata};
               is_read_d = bus.rw;
               nss_d     = 1'b0;
               mosi_d    = bus.rw;
               busy_d    = 1'b1;
            end
         end
         StSetup: begin
            if (cnt_q == '0) begin
               state_d = StXfer;
               cnt_d   = Reload;
               hp_d    = '0;
            end
         end
         StXfer: begin
            if (cnt_q == '0) begin
               cnt_d = Reload;
               hp_d  = hp_q + 5'd1;
               sck_d = ~sck_q;
               if (sck_q && (hp_q == 5'd31)) begin
                  state_d = StHold;
               end else if (sck_q) begin
                  // Rotate rather than shift so the MSB always feeds mosi from bit 15
                  sreg_d = {sreg_q[14:0], sreg_q[15]};
                  mosi_d = sreg_q[14];
               end
            end
         end
         StHold: begin
            if (cnt_q == '0) begin
               state_d = StGap;
               cnt_d   = Reload;
               nss_d   = 1'b1;
               mosi_d  = 1'b0;
            end
         end
         StGap: begin
            if (cnt_q == '0) begin
               state_d = StIdle;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               if (is_read_q) begin
                  rdata_d = rshift_q;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         hp_q      <= '0;
         sreg_q    <= '0;
         rshift_q  <= '0;
         rdata_q   <= '0;
         is_read_q <= 1'b0;
         sck_q     <= 1'b0;
         nss_q     <= 1'b1;
         mosi_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef SPI_MISO_SYNC_EN
         sync_q    <= '0;
         smp_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hp_q      <= hp_d;
         sreg_q    <= sreg_d;
         rshift_q  <= rshift_d;
         rdata_q   <= rdata_d;
         is_read_q <= is_read_d;
         sck_q     <= sck_d;
         nss_q     <= nss_d;
         mosi_q    <= mosi_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef SPI_MISO_SYNC_EN
         sync_q    <= {sync_q[0], bus.miso};
         smp_q     <= smp_d;
`endif
      end
   end

   assign bus.sck   = sck_q;
   assign bus.nss   = nss_q;
   assign bus.mosi  = mosi_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.rdata = rdata_q;

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI initiator (mode 0, MSB first) driving the CPLD's SPI responder (sck/nss/mosi/miso) from a host-side parallel request interface.
- Issues one 16-bit frame per request: command byte {rw, addr[6:0]}, then data byte.
- Used by the bench/host FPGA to read and write LEDs, switches and SRAM over the CPLD bus.

Parameters:
- CLK_DIV, 4, clk cycles per sck half-period; legal range 2..255 (3..255 with SPI_MISO_SYNC_EN).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request strobe; sampled only in IDLE
- rw  input  1  1 = read, 0 = write; becomes command bit 7
- addr  input  7  target bus address
- wdata  input  8  write data byte
- busy  output  1  high from the cycle after accept until done
- done  output  1  one-cycle pulse at frame end
- rdata  output  8  read data; updated only by read frames
- sck  output  1  SPI clock, idle low
- nss  output  1  slave select, active low
- mosi  output  1  serial data out
- miso  input  1  serial data in

Behaviour:
- Clocking/reset: one clock, clk; reset_n is asynchronous, active-low. Reset, including mid-frame, forces nss=1, sck=0, mosi=0, busy=0, done=0, rdata=0x00 and state IDLE immediately. No partial frame resumes.
- Request capture: in IDLE with start=1, latch shift register sreg = {rw, addr, rw ? 8'h00 : wdata}. Inputs are ignored after the accept cycle.
- States:
  - IDLE: nss=1, sck=0, busy=0. On start, go to SETUP; busy=1 from the next cycle.
  - SETUP: nss=0, sck=0, mosi=sreg[15], for CLK_DIV cycles.
  - XFER: sck toggles every CLK_DIV cycles, 32 half-periods, 16 rising edges.
    - Rising edge n (1..16): sample miso. For n>=9 on a read frame, shift into rdata_shift.
    - Falling edge after rising edge n (n<=15): mosi = next bit.
    - After the 16th falling edge, sck=0; go to HOLD.
  - HOLD: nss=0, sck=0, for CLK_DIV cycles, then go to GAP.
  - GAP: nss=1, mosi=0, for CLK_DIV cycles. On the last cycle, read frames load rdata from rdata_shift.
  - Exit: next cycle done=1, busy=0, state IDLE.
- Latency: accept to done pulse = 35*CLK_DIV + 1 cycles (CLK_DIV=4 gives 141).
- Timing rules:
  - Half-period counter reloads on every state change.
  - sck is a registered output with no glitches.
  - mosi changes only on sck falling edges or state entry, never on rising edges.
- start while busy=1 is ignored and not queued.
- start in the done cycle is accepted; back-to-back frames keep the GAP nss-high time of CLK_DIV cycles.
- rdata is stable between read completions. Write frames leave it unchanged.
- miso is "don't care" during the command byte.

Optional Feature:
- Macro: SPI_MISO_SYNC_EN.
- Defined:
  - miso passes through a 2-flop synchronizer.
  - Each sample is taken 2 clk cycles after the sck rising edge.
  - Requires CLK_DIV>=3.
  - Latency unchanged.
- Undefined:
  - miso is sampled directly in the clk cycle in which sck rises.

Test Plan:
- Reset, then idle 20 cycles -> nss=1, sck=0, mosi=0, busy=0, done=0, rdata=0x00 throughout.
- CLK_DIV=4, write rw=0 addr=0x05 wdata=0xA5 -> mosi sampled at sck rises = 0x05 then 0xA5; nss low 34*4 cycles; done at cycle 141; rdata stays 0x00.
- Read rw=1 addr=0x10, slave model returns 0x3C in byte 2 -> command byte 0x90; mosi=0 during byte 2; rdata=0x3C at done; busy low the same cycle.
- start pulsed at cycles 10 and 60 of a frame -> ignored; exactly one done pulse. start held in the done cycle -> second frame begins, nss high for exactly 4 cycles between frames.
- reset_n low at rising edge 7 of a read frame -> nss=1, sck=0 asynchronously. After release, no done pulse and rdata=0x00. A new frame then completes normally.
- With SPI_MISO_SYNC_EN, CLK_DIV=3, read returning 0xC3 -> rdata=0xC3; repeat without the macro, CLK_DIV=2 -> rdata=0xC3.
